// File: rtl/mc14433_pkg.sv
// Shared types and constants for the MC14433 multiplexed-output receiver.
package mc14433_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      C1   = 3'd2,
      C2   = 3'd3,
      C3   = 3'd4,
      C4   = 3'd5,
      CONV = 3'd6,
      PUB  = 3'd7
   } state_e;

   localparam int MAX_COUNT = 1999;

   localparam int HALF_N = 3;
   localparam int POL    = 2;
   localparam int RANGE  = 0;

   localparam logic [3:0]  BCD_MAX     = 4'd9;
   localparam logic [11:0] BIN_POS_MAX = 12'(MAX_COUNT);
   localparam logic [11:0] BIN_NEG_MAX = 12'd0 - BIN_POS_MAX;

   function automatic logic multi_hot(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

   function automatic logic one_hot(input logic [3:0] v);
      return (v != 4'd0) && !multi_hot(v);
   endfunction

endpackage

// File: rtl/mc14433_bcd2bin.sv
// Combinational 3.5-digit BCD reading to 12-bit two's-complement value.
module mc14433_bcd2bin
   import mc14433_pkg::*;
(
   input  logic        half,
   input  logic [3:0]  d2,
   input  logic [3:0]  d3,
   input  logic [3:0]  d4,
   input  logic        pos,
   input  logic        over,
   input  logic        under,
   output logic [11:0] bin
);

   logic [11:0] mag_s;

   // Range flags override the digits, which may hold garbage when out of range.
   always_comb begin
      mag_s = ({11'd0, half} * 12'd1000) + ({8'd0, d2} * 12'd100)
            + ({8'd0, d3} * 12'd10) + {8'd0, d4};
      if (over) begin
         bin = BIN_POS_MAX;
      end else if (under) begin
         bin = BIN_NEG_MAX;
      end else if (pos) begin
         bin = mag_s;
      end else begin
         bin = 12'd0 - mag_s;
      end
   end

endmodule

// File: rtl/mc14433_readout.sv
// Receiver for the MC14433 DS/Q multiplexed result: frame capture, check,
// conversion to signed binary and valid/ready hand-off.
module mc14433_readout
   import mc14433_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE      = 3,
   parameter int TIMEOUT     = 4095
) (
   input  logic        CP,
   input  logic        R,
   input  logic        EOC,
   input  logic [3:0]  DS,
   input  logic [3:0]  Q,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic [12:0] rd_bcd,
   output logic        rd_pos,
   output logic        rd_over,
   output logic        rd_under,
   output logic [11:0] rd_bin,
   output logic        frame_err,
   output logic        overrun
);

   localparam int RUN_W = $clog2(SETTLE + 2);
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [RUN_W-1:0] RUN_SET = RUN_W'(SETTLE);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SETTLE + 1);
   localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);

   logic [SYNC_STAGES-1:0][8:0] sync_q, sync_d;
   logic                eoc_prev_q, eoc_prev_d;
   logic [3:0]          ds_prev_q, ds_prev_d;
   logic [RUN_W-1:0]    run_q, run_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   state_e              state_q, state_d;
   logic                half_n_q, half_n_d, pol_q, pol_d, range_q, range_d;
   logic [3:0]          d2_q, d2_d, d3_q, d3_d, d4_q, d4_d;
   logic [11:0]         bin_q, bin_d;
   logic                rd_valid_q, rd_valid_d;
   logic [12:0]         rd_bcd_q, rd_bcd_d;
   logic                rd_pos_q, rd_pos_d, rd_over_q, rd_over_d, rd_under_q, rd_under_d;
   logic [11:0]         rd_bin_q, rd_bin_d;
   logic                frame_err_q, frame_err_d, overrun_q, overrun_d;

   logic                eoc_s, eoc_rise_s, stable_s, in_frame_s, capture_s, abort_s;
   logic [3:0]          ds_s, q_s, exp_s;
   logic [11:0]         bin_s;

   mc14433_bcd2bin u_bcd2bin (
      .half  (~half_n_q),
      .d2    (d2_q),
      .d3    (d3_q),
      .d4    (d4_q),
      .pos   (pol_q),
      .over  (range_q & ~half_n_q),
      .under (range_q & half_n_q),
      .bin   (bin_s)
   );

   // Input synchronisers, edge detection and strobe settle counter.
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-2:0], {EOC, DS, Q}};
      eoc_s      = sync_q[SYNC_STAGES-1][8];
      ds_s       = sync_q[SYNC_STAGES-1][7:4];
      q_s        = sync_q[SYNC_STAGES-1][3:0];
      eoc_prev_d = eoc_s;
      ds_prev_d  = ds_s;
      eoc_rise_s = eoc_s & ~eoc_prev_q;
      if (ds_s != ds_prev_q) begin
         run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
         run_d = run_q + RUN_W'(1);
      end else begin
         run_d = run_q;
      end
      // Fires exactly once per strobe assertion: run_d saturates past RUN_SET.
      stable_s = one_hot(ds_s) && (run_d == RUN_SET);
   end

   // Frame FSM, frame checks and output handshake.
   always_comb begin
      state_d     = state_q;
      half_n_d    = half_n_q;
      pol_d       = pol_q;
      range_d     = range_q;
      d2_d        = d2_q;
      d3_d        = d3_q;
      d4_d        = d4_q;
      bin_d       = bin_q;
      rd_bcd_d    = rd_bcd_q;
      rd_pos_d    = rd_pos_q;
      rd_over_d   = rd_over_q;
      rd_under_d  = rd_under_q;
      rd_bin_d    = rd_bin_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      in_frame_s = (state_q == ARM) || (state_q == C1) || (state_q == C2) || (state_q == C3);
      case (state_q)
         ARM:     exp_s = 4'b0001;
         C1:      exp_s = 4'b0010;
         C2:      exp_s = 4'b0100;
         C3:      exp_s = 4'b1000;
         default: exp_s = 4'b0000;
      endcase
      capture_s = stable_s && (ds_s == exp_s);
      abort_s   = in_frame_s && (multi_hot(ds_s)
                  || (stable_s && (ds_s != exp_s))
                  || (capture_s && (state_q != ARM) && (q_s > BCD_MAX) && !range_q)
                  || ((to_cnt_q == TO_LIM) && !capture_s)
                  || eoc_rise_s);

      if (!in_frame_s || capture_s) begin
         to_cnt_d = {TO_W{1'b0}};
      end else if (to_cnt_q != TO_LIM) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end else begin
         to_cnt_d = to_cnt_q;
      end

      case (state_q)
         IDLE: begin
            if (eoc_rise_s) begin
               state_d = ARM;
            end else begin
               state_d = IDLE;
            end
         end
         ARM, C1, C2, C3: begin
            if (abort_s) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end else if (capture_s) begin
               case (state_q)
                  ARM: begin
                     half_n_d = q_s[HALF_N];
                     pol_d    = q_s[POL];
                     range_d  = q_s[RANGE];
                     state_d  = C1;
                  end
                  C1: begin
                     d2_d    = q_s;
                     state_d = C2;
                  end
                  C2: begin
                     d3_d    = q_s;
                     state_d = C3;
                  end
                  C3: begin
                     d4_d    = q_s;
                     state_d = C4;
                  end
                  default: state_d = IDLE;
               endcase
            end else begin
               state_d = state_q;
            end
         end
         C4:   state_d = CONV;
         CONV: begin
            bin_d   = bin_s;
            state_d = PUB;
         end
         PUB: begin
            rd_bcd_d   = {~half_n_q, d2_q, d3_q, d4_q};
            rd_pos_d   = pol_q;
            rd_over_d  = range_q & ~half_n_q;
            rd_under_d = range_q & half_n_q;
            rd_bin_d   = bin_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A publish always leaves rd_valid high; it only overruns if the old reading was not taken.
      if (state_q == PUB) begin
         rd_valid_d = 1'b1;
         overrun_d  = rd_valid_q && !rd_ready;
      end else if (rd_valid_q && rd_ready) begin
         rd_valid_d = 1'b0;
      end else begin
         rd_valid_d = rd_valid_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge CP or negedge R) begin
      if (!R) begin
         sync_q      <= '0;
         eoc_prev_q  <= 1'b0;
         ds_prev_q   <= 4'd0;
         run_q       <= {RUN_W{1'b0}};
         to_cnt_q    <= {TO_W{1'b0}};
         state_q     <= IDLE;
         half_n_q    <= 1'b0;
         pol_q       <= 1'b0;
         range_q     <= 1'b0;
         d2_q        <= 4'd0;
         d3_q        <= 4'd0;
         d4_q        <= 4'd0;
         bin_q       <= 12'd0;
         rd_valid_q  <= 1'b0;
         rd_bcd_q    <= 13'd0;
         rd_pos_q    <= 1'b0;
         rd_over_q   <= 1'b0;
         rd_under_q  <= 1'b0;
         rd_bin_q    <= 12'd0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= sync_d;
         eoc_prev_q  <= eoc_prev_d;
         ds_prev_q   <= ds_prev_d;
         run_q       <= run_d;
         to_cnt_q    <= to_cnt_d;
         state_q     <= state_d;
         half_n_q    <= half_n_d;
         pol_q       <= pol_d;
         range_q     <= range_d;
         d2_q        <= d2_d;
         d3_q        <= d3_d;
         d4_q        <= d4_d;
         bin_q       <= bin_d;
         rd_valid_q  <= rd_valid_d;
         rd_bcd_q    <= rd_bcd_d;
         rd_pos_q    <= rd_pos_d;
         rd_over_q   <= rd_over_d;
         rd_under_q  <= rd_under_d;
         rd_bin_q    <= rd_bin_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_bcd    = rd_bcd_q;
   assign rd_pos    = rd_pos_q;
   assign rd_over   = rd_over_q;
   assign rd_under  = rd_under_q;
   assign rd_bin    = rd_bin_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_mc14433_readout.sv
// Directed self-checking bench for mc14433_readout.
module tb_mc14433_readout;

   localparam int SYNC_STAGES = 2;
   localparam int SETTLE      = 3;
   localparam int TIMEOUT     = 4095;
   localparam int HOLD        = 6;
   localparam int LAT         = SYNC_STAGES + SETTLE + 3;

   logic        CP = 1'b0;
   logic        R = 1'b0;
   logic        EOC = 1'b0;
   logic [3:0]  DS = 4'd0;
   logic [3:0]  Q = 4'd0;
   logic        rd_ready = 1'b1;
   logic        rd_valid, rd_pos, rd_over, rd_under, frame_err, overrun;
   logic [12:0] rd_bcd;
   logic [11:0] rd_bin;

   int n_chk = 0;
   int n_fail = 0;
   int err_cnt = 0;
   int ovr_cnt = 0;
   int vld_cnt = 0;
   int cyc = 0;
   int ds4_cyc = 0;

   mc14433_readout #(.SYNC_STAGES(SYNC_STAGES), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
      .CP(CP), .R(R), .EOC(EOC), .DS(DS), .Q(Q),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bcd(rd_bcd), .rd_pos(rd_pos),
      .rd_over(rd_over), .rd_under(rd_under), .rd_bin(rd_bin),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #5 CP = ~CP;

   always @(posedge CP) cyc <= cyc + 1;

   always @(negedge CP) begin
      if (R) begin
         if (frame_err) err_cnt <= err_cnt + 1;
         if (overrun)   ovr_cnt <= ovr_cnt + 1;
         if (rd_valid)  vld_cnt <= vld_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CP);
   endtask

   task automatic eoc_pulse();
      EOC = 1'b1;
      tick(2);
      EOC = 1'b0;
      tick(3);
   endtask

   task automatic strobe(input logic [3:0] ds, input logic [3:0] q);
      DS = ds;
      Q  = q;
      tick(HOLD);
   endtask

   task automatic send_frame(input logic [3:0] st, input logic [3:0] d2,
                             input logic [3:0] d3, input logic [3:0] d4);
      eoc_pulse();
      strobe(4'b0001, st);
      strobe(4'b0010, d2);
      strobe(4'b0100, d3);
      DS = 4'b1000;
      Q  = d4;
      ds4_cyc = cyc;
      tick(HOLD);
      DS = 4'd0;
      Q  = 4'd0;
   endtask

   task automatic wait_valid(output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (rd_valid === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge CP);
      end
   endtask

   task automatic test_reset();
      R = 1'b0;
      tick(4);
      n_chk++;
      if ({rd_valid, rd_bcd, rd_pos, rd_over, rd_under, rd_bin, frame_err, overrun} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {rd_valid, rd_bcd, rd_pos, rd_over, rd_under, rd_bin, frame_err, overrun});
      end
      R = 1'b1;
      tick(3);
   endtask

   task automatic test_frame(input string nm, input logic [3:0] st, input logic [3:0] d2,
                             input logic [3:0] d3, input logic [3:0] d4,
                             input logic [12:0] e_bcd, input logic e_pos, input logic e_over,
                             input logic e_under, input logic [11:0] e_bin);
      bit got;
      int e0;
      int lat;
      e0 = err_cnt;
      send_frame(st, d2, d3, d4);
      wait_valid(got);
      lat = cyc - ds4_cyc;
      n_chk++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b expected 1", nm, got); end
      n_chk++;
      if (lat != LAT) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", nm, lat, LAT); end
      n_chk++;
      if (rd_bcd !== e_bcd) begin n_fail++; $display("FAIL %s_bcd: got %h expected %h", nm, rd_bcd, e_bcd); end
      n_chk++;
      if (rd_pos !== e_pos) begin n_fail++; $display("FAIL %s_pos: got %b expected %b", nm, rd_pos, e_pos); end
      n_chk++;
      if ({rd_over, rd_under} !== {e_over, e_under}) begin
         n_fail++;
         $display("FAIL %s_range: got %b%b expected %b%b", nm, rd_over, rd_under, e_over, e_under);
      end
      n_chk++;
      if (rd_bin !== e_bin) begin n_fail++; $display("FAIL %s_bin: got %h expected %h", nm, rd_bin, e_bin); end
      @(negedge CP);
      n_chk++;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s_taken: got %b expected 0", nm, rd_valid); end
      tick(2);
      n_chk++;
      if (err_cnt != e0) begin n_fail++; $display("FAIL %s_noerr: got %0d expected %0d", nm, err_cnt - e0, 0); end
   endtask

   // Runs right after the under-range frame, whose values must survive every abort.
   task automatic test_errors();
      int e0;
      int v0;
      for (int k = 0; k < 4; k++) begin
         e0 = err_cnt;
         v0 = vld_cnt;
         eoc_pulse();
         case (k)
            0: begin
               strobe(4'b0001, 4'b0100);
               strobe(4'b0100, 4'd8);
               strobe(4'b1000, 4'd7);
            end
            1: strobe(4'b0011, 4'd0);
            2: begin
               strobe(4'b0001, 4'b0100);
               strobe(4'b0010, 4'd1);
               strobe(4'b0100, 4'hB);
               strobe(4'b1000, 4'd2);
            end
            default: begin
               tick(TIMEOUT - 20);
               n_chk++;
               if (err_cnt != e0) begin
                  n_fail++;
                  $display("FAIL err_timeout_early: got %0d expected 0", err_cnt - e0);
               end
               tick(40);
            end
         endcase
         DS = 4'd0;
         Q  = 4'd0;
         tick(20);
         n_chk++;
         if (err_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL err%0d_pulses: got %0d expected 1", k, err_cnt - e0);
         end
         n_chk++;
         if (vld_cnt != v0) begin
            n_fail++;
            $display("FAIL err%0d_valid: got %0d expected 0", k, vld_cnt - v0);
         end
         n_chk++;
         if ({rd_bcd, rd_pos, rd_over, rd_under, rd_bin} !== {13'h0FAC, 1'b0, 1'b0, 1'b1, 12'h831}) begin
            n_fail++;
            $display("FAIL err%0d_hold: got %h expected %h", k, {rd_bcd, rd_pos, rd_over, rd_under, rd_bin},
                     {13'h0FAC, 1'b0, 1'b0, 1'b1, 12'h831});
         end
      end
   endtask

   task automatic test_back_to_back();
      bit got;
      int o0;
      o0 = ovr_cnt;
      rd_ready = 1'b0;
      send_frame(4'b0100, 4'd9, 4'd8, 4'd7);
      wait_valid(got);
      n_chk++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b expected 1", got); end
      send_frame(4'b1000, 4'd0, 4'd4, 4'd2);
      tick(10);
      n_chk++;
      if (ovr_cnt - o0 != 1) begin n_fail++; $display("FAIL bp_overrun: got %0d expected 1", ovr_cnt - o0); end
      n_chk++;
      if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b expected 1", rd_valid); end
      n_chk++;
      if (rd_bin !== 12'hFD6) begin n_fail++; $display("FAIL bp_bin: got %h expected fd6", rd_bin); end
      n_chk++;
      if (rd_bcd !== 13'h0042) begin n_fail++; $display("FAIL bp_bcd: got %h expected 0042", rd_bcd); end
      rd_ready = 1'b1;
      @(negedge CP);
      n_chk++;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", rd_valid); end
      tick(2);
   endtask

   task automatic test_reset_midframe();
      bit got;
      int e0;
      eoc_pulse();
      strobe(4'b0001, 4'b0000);
      strobe(4'b0010, 4'd1);
      R = 1'b0;
      #1;
      n_chk++;
      if ({rd_valid, rd_bcd, rd_pos, rd_over, rd_under, rd_bin, frame_err, overrun} !== 31'd0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %h expected 0",
                  {rd_valid, rd_bcd, rd_pos, rd_over, rd_under, rd_bin, frame_err, overrun});
      end
      tick(3);
      DS = 4'd0;
      Q  = 4'd0;
      R  = 1'b1;
      tick(3);
      e0 = err_cnt;
      send_frame(4'b0000, 4'd1, 4'd2, 4'd3);
      wait_valid(got);
      n_chk++;
      if (got !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 1", got); end
      n_chk++;
      if (rd_bcd !== 13'h1123) begin n_fail++; $display("FAIL post_reset_bcd: got %h expected 1123", rd_bcd); end
      n_chk++;
      if (rd_pos !== 1'b0) begin n_fail++; $display("FAIL post_reset_pos: got %b expected 0", rd_pos); end
      n_chk++;
      if (rd_bin !== 12'hB9D) begin n_fail++; $display("FAIL post_reset_bin: got %h expected b9d", rd_bin); end
      tick(3);
      n_chk++;
      if (err_cnt != e0) begin n_fail++; $display("FAIL post_reset_noerr: got %0d expected 0", err_cnt - e0); end
   endtask

   initial begin
      test_reset();
      test_frame("nominal",  4'b0100, 4'd9, 4'd8, 4'd7, 13'h1987, 1'b1, 1'b0, 1'b0, 12'h7C3);
      test_frame("negative", 4'b1000, 4'd0, 4'd4, 4'd2, 13'h0042, 1'b0, 1'b0, 1'b0, 12'hFD6);
      test_frame("negzero",  4'b1000, 4'd0, 4'd0, 4'd0, 13'h0000, 1'b0, 1'b0, 1'b0, 12'h000);
      test_frame("over",     4'b0001, 4'hF, 4'hF, 4'hF, 13'h1FFF, 1'b0, 1'b1, 1'b0, 12'h7CF);
      test_frame("under",    4'b1001, 4'hF, 4'hA, 4'hC, 13'h0FAC, 1'b0, 1'b0, 1'b1, 12'h831);
      test_errors();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
